// File: rtl/ps2_key_decoder_pkg.sv
// ps2_pkg: shared scancode constants, byte FSM states and the scancode-to-ASCII map.
// Contents: BREAK_CODE, EXT_CODE, state_t and scan2ascii (0x00 for unmapped codes).
package ps2_pkg;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  function automatic logic [7:0] scan2ascii(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h16: a = "1";
      8'h1E: a = "2";
      8'h26: a = "3";
      8'h25: a = "4";
      8'h2E: a = "5";
      8'h36: a = "6";
      8'h3D: a = "7";
      8'h15: a = "q";
      8'h1D: a = "w";
      8'h24: a = "e";
      8'h2D: a = "r";
      8'h2C: a = "t";
      8'h35: a = "y";
      8'h3C: a = "u";
      8'h1C: a = "a";
      8'h1B: a = "s";
      8'h23: a = "d";
      8'h2B: a = "f";
      8'h34: a = "g";
      8'h33: a = "h";
      8'h3B: a = "j";
      default: a = 8'h00;
    endcase
    return a;
  endfunction
endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: PS/2 pins plus decoded key outputs.
// Signals: ps2_clk/ps2_data (raw pins), ps2_asci (held key), key_valid and frame_err pulses.
// slave is the decoder side, master is the keyboard/consumer side.
interface ps2_key_decoder_if;
  logic ps2_clk;
  logic ps2_data;
  logic [7:0] ps2_asci;
  logic key_valid;
  logic frame_err;
  modport master(output ps2_clk, ps2_data, input ps2_asci, key_valid, frame_err);
  modport slave(input ps2_clk, ps2_data, output ps2_asci, key_valid, frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronises the PS/2 pins and receives 11-bit frames with watchdog.
// Ports: clk_5MHz, rst, ps2_clk_i, ps2_data_i in; rx_byte_o with one-cycle rx_strobe_o
// on a good frame, rx_err_o one-cycle pulse on a bad or timed-out frame.
module ps2_rx_frame #(
  parameter int TIMEOUT_CYC = 2500,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_5MHz,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_strobe_o,
  output logic       rx_err_o
);
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic clk_prev_q, strobe_q, err_q;
  logic [3:0] cnt_q;
  logic [9:0] sr_q;
  logic [7:0] byte_q;
  logic [WD_W-1:0] wd_q;
  logic fall, bit_s, last, frame_ok, timeout;
  assign fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_s = data_sync_q[SYNC_STAGES-1];
  assign last = cnt_q == 4'd10;
  // sr_q holds start, d0..d7, parity; the stop bit is the sample taken on this edge
  assign frame_ok = ~sr_q[0] & bit_s & ^sr_q[9:1];
  assign timeout = ~fall && cnt_q != 4'd0 && wd_q == WD_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk_5MHz) begin
    if (rst) begin
      clk_sync_q <= '1;
      data_sync_q <= '1;
      clk_prev_q <= 1'b1;
      cnt_q <= '0;
      sr_q <= '0;
      wd_q <= '0;
      byte_q <= '0;
      strobe_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
      strobe_q <= fall & last & frame_ok;
      err_q <= (fall & last & ~frame_ok) | timeout;
      if (fall & last) byte_q <= sr_q[8:1];
      sr_q <= fall ? {bit_s, sr_q[9:1]} : sr_q;
      cnt_q <= (timeout || (fall && last)) ? 4'd0 : fall ? cnt_q + 4'd1 : cnt_q;
      wd_q <= (fall || cnt_q == 4'd0 || timeout) ? '0 : wd_q + 1'b1;
    end
  end
  assign rx_byte_o = byte_q;
  assign rx_strobe_o = strobe_q;
  assign rx_err_o = err_q;
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: decodes PS/2 make/break scancodes into the ASCII of the held piano key.
// Ports: clk_5MHz, rst, bus (slave: ps2_clk/ps2_data in; ps2_asci, key_valid, frame_err out).
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2500,
  parameter int SYNC_STAGES = 2
) (
  input logic clk_5MHz,
  input logic rst,
  ps2_key_decoder_if.slave bus
);
  logic [7:0] rx_byte, code, asci_q;
  logic rx_strobe, rx_err, kv_q, err_q;
  state_t state_q;
  ps2_rx_frame #(.TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk_5MHz(clk_5MHz),
    .rst(rst),
    .ps2_clk_i(bus.ps2_clk),
    .ps2_data_i(bus.ps2_data),
    .rx_byte_o(rx_byte),
    .rx_strobe_o(rx_strobe),
    .rx_err_o(rx_err)
  );
  assign code = scan2ascii(rx_byte);
  always_ff @(posedge clk_5MHz) begin
    if (rst) begin
      state_q <= IDLE;
      asci_q <= '0;
      kv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= rx_err;
      kv_q <= 1'b0;
      if (rx_err) state_q <= IDLE;
      else if (rx_strobe) begin
        if (rx_byte == EXT_CODE) state_q <= EXT;
        else if (rx_byte == BREAK_CODE) state_q <= (state_q == EXT || state_q == EXT_BRK) ? EXT_BRK : BRK;
        else begin
          state_q <= IDLE;
          // repeats of the held key and breaks of other keys leave the output alone
          if (state_q == IDLE && code != 8'h00 && code != asci_q) begin
            asci_q <= code;
            kv_q <= 1'b1;
          end else if (state_q == BRK && asci_q != 8'h00 && code == asci_q) begin
            asci_q <= 8'h00;
            kv_q <= 1'b1;
          end
        end
      end
    end
  end
  assign bus.ps2_asci = asci_q;
  assign bus.key_valid = kv_q;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed and random PS/2 frames checked against a scancode-level model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
  localparam int T = 2500;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #100 clk = ~clk;
  ps2_key_decoder_if bus();
  ps2_key_decoder dut (.clk_5MHz(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  int cyc = 0, fall_cyc = 0, kv_cyc = 0, err_cyc = 0, kv_cnt = 0, err_cnt = 0;
  logic [7:0] prev_asci = 8'h00;
  logic [7:0] codes [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C,
                              8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B};
  string keys = "1234567qwertyuasdfghj";
  logic [7:0] held = 8'h00;
  bit pre_ext = 0, pre_brk = 0;
  int exp_kv = 0, exp_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ref_map(input logic [7:0] c);
    foreach (codes[i]) if (codes[i] == c) return keys[i];
    return 8'h00;
  endfunction
  // Keyboard-level meaning of one received byte: prefixes, then a make or break of a key
  task automatic model_byte(input logic [7:0] b, input bit bad);
    logic [7:0] a;
    if (bad) begin
      exp_err++;
      pre_ext = 0;
      pre_brk = 0;
    end else if (b == 8'hE0) begin
      pre_ext = 1;
      pre_brk = 0;
    end else if (b == 8'hF0) pre_brk = 1;
    else begin
      a = ref_map(b);
      if (!pre_ext && a != 8'h00) begin
        if (pre_brk) begin
          if (a == held) begin held = 8'h00; exp_kv++; end
        end else if (a != held) begin
          held = a;
          exp_kv++;
        end
      end
      pre_ext = 0;
      pre_brk = 0;
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.key_valid) begin kv_cnt++; kv_cyc = cyc; end
      if (bus.frame_err) begin err_cnt++; err_cyc = cyc; end
      if (bus.key_valid && bus.frame_err) check("kv_err_same_cycle", 1, 0);
      if (bus.key_valid || bus.ps2_asci != prev_asci)
        check("kv_with_change", {31'd0, bus.key_valid && bus.ps2_asci != prev_asci}, 1);
    end
    prev_asci = bus.ps2_asci;
  end
  task automatic ps2_bit(input bit v, input int half);
    bus.ps2_data = v;
    repeat (half) @(negedge clk);
    bus.ps2_clk = 1'b0;
    fall_cyc = cyc;
    repeat (half) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input bit bad, input int half);
    logic [10:0] bits;
    bits = {1'b1, ~^b ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i], half);
    model_byte(b, bad);
    repeat (4) @(negedge clk);
    check("asci", {24'd0, bus.ps2_asci}, {24'd0, held});
    check("kv_count", kv_cnt, exp_kv);
    check("err_count", err_cnt, exp_err);
  endtask
  initial begin
    logic [10:0] bits;
    int e0, f5, r, half;
    logic [7:0] b;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_asci", {24'd0, bus.ps2_asci}, 0);
    check("rst_kv", {31'd0, bus.key_valid}, 0);
    check("rst_err", {31'd0, bus.frame_err}, 0);
    rst = 1'b0;
    repeat (10000) @(negedge clk);
    check("idle_asci", {24'd0, bus.ps2_asci}, 0);
    check("idle_pulses", kv_cnt + err_cnt, 0);
    send(8'h1C, 0, 200);
    check("make_a_latency", kv_cyc - fall_cyc, 4);
    check("make_a_value", {24'd0, bus.ps2_asci}, 8'h61);
    send(8'hF0, 0, 20);
    send(8'h1C, 0, 20);
    check("break_a_value", {24'd0, bus.ps2_asci}, 0);
    e0 = kv_cnt;
    send(8'h1C, 0, 10);
    send(8'h1B, 0, 10);
    check("last_wins", {24'd0, bus.ps2_asci}, 8'h73);
    send(8'hF0, 0, 10);
    send(8'h1C, 0, 10);
    check("other_break_ignored", {24'd0, bus.ps2_asci}, 8'h73);
    send(8'hF0, 0, 10);
    send(8'h1B, 0, 10);
    check("three_pulses", kv_cnt - e0, 3);
    send(8'h23, 1, 10);
    check("parity_err_keeps", {24'd0, bus.ps2_asci}, 0);
    send(8'h23, 0, 10);
    check("after_err_d", {24'd0, bus.ps2_asci}, 8'h64);
    bits = {1'b1, ~^8'h2B, 8'h2B, 1'b0};
    for (int i = 0; i < 5; i++) ps2_bit(bits[i], 10);
    f5 = fall_cyc;
    e0 = err_cnt;
    repeat (T + 40) @(negedge clk);
    model_byte(8'h00, 1);
    check("timeout_err", err_cnt, e0 + 1);
    check("timeout_delay", {31'd0, (err_cyc - f5) >= T && (err_cyc - f5) <= T + 5}, 1);
    send(8'h2B, 0, 10);
    send(8'hF0, 0, 10);
    send(8'h2B, 0, 10);
    e0 = kv_cnt;
    send(8'hE0, 0, 8);
    send(8'h75, 0, 8);
    send(8'hE0, 0, 8);
    send(8'hF0, 0, 8);
    send(8'h75, 0, 8);
    send(8'hF0, 0, 8);
    send(8'h1C, 0, 8);
    check("ext_no_pulse", kv_cnt, e0);
    send(8'h34, 0, 8);
    bits = {1'b1, ~^8'h16, 8'h16, 1'b0};
    for (int i = 0; i < 3; i++) ps2_bit(bits[i], 8);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    held = 8'h00;
    pre_ext = 0;
    pre_brk = 0;
    check("midrst_asci", {24'd0, bus.ps2_asci}, 0);
    check("midrst_pulses", {30'd0, bus.key_valid, bus.frame_err}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h16, 0, 8);
    check("after_rst_1", {24'd0, bus.ps2_asci}, 8'h31);
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      b = r < 5 ? codes[$urandom_range(0, 20)] : r == 5 ? 8'hF0 : r == 6 ? 8'hE0 : 8'($urandom);
      half = $urandom_range(4, 12);
      send(b, $urandom_range(0, 11) == 0, half);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Upstream feeder of the record/replay stage. Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and decodes make/break scancodes. Presents the ASCII code of the currently held piano key on ps2_asci, or 0x00 when no key is held. All logic runs in the clk_5MHz domain.

Parameters:
TIMEOUT_CYC, 2500, clk_5MHz cycles without a ps2_clk falling edge mid-frame before the partial frame is discarded (500 us)
SYNC_STAGES, 2, synchroniser depth on ps2_clk and ps2_data

Ports:
clk_5MHz  in  1  system clock, 5 MHz
rst  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous, idle high
ps2_data  in  1  raw PS/2 data pin, asynchronous, idle high
ps2_asci  out  8  ASCII of the held key; 0x00 when none
key_valid  out  1  one-cycle pulse whenever ps2_asci changes value
frame_err  out  1  one-cycle pulse on a discarded frame (parity, start, stop or timeout)

Behaviour:
- Reset: ps2_asci=0x00, key_valid=0, frame_err=0. Bit counter=0. Break and extended flags cleared. Watchdog cleared. Reset is honoured mid-frame; the partial frame is lost.
- Sync: both pins pass through SYNC_STAGES flops. A falling edge is synced previous=1 and current=0. Data is sampled on the detected edge.
- Frame: 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1). A 4-bit counter goes 0..10 and a shift register captures the bits.
- Frame check after bit 10: start==0, stop==1, and XOR(d0..d7,parity)==1. Any failure discards the frame, pulses frame_err, and clears the break and extended flags.
- Watchdog: counts cycles while the bit counter is nonzero and resets on each edge. When it reaches TIMEOUT_CYC, the counter returns to 0 and frame_err pulses. The watchdog is idle when the counter is 0.
- Byte handling FSM, states IDLE / BRK / EXT / EXT_BRK:
  - 0xE0 moves to EXT.
  - 0xF0 moves to BRK, or from EXT to EXT_BRK.
  - Any other byte in EXT or EXT_BRK is ignored and returns to IDLE. Extended keys are unsupported.
  - In IDLE, a mapped code is a make. In BRK, a mapped code is a break. Both then return to IDLE.
- Make of a mapped key sets ps2_asci to its ASCII value; the last-pressed key wins.
- Break clears ps2_asci to 0x00 only if the code maps to the currently held value. A break of a different key is ignored.
- Typematic repeat of the held key leaves ps2_asci unchanged with no key_valid pulse.
- Unmapped codes are ignored, including 0xAA (BAT) and 0xFA (ACK).
- key_valid pulses in the same cycle ps2_asci takes its new value.
- Latency: ps2_asci updates exactly SYNC_STAGES+2 cycles after the pin-level 11th falling edge (4 cycles at default). The +2 covers one cycle for edge detect and one for the decode register.
- Frame_err and key_valid never pulse in the same cycle.

Decomposition:
- Package ps2_pkg holds:
  - The byte constants BREAK_CODE=0xF0, EXT_CODE=0xE0 and the FSM state enum.
  - The scancode-to-ASCII function, returning 0x00 for unmapped codes.
  - Keys 1..7 (16,1E,26,25,2E,36,3D) map to '1'..'7'.
  - Keys q w e r t y u (15,1D,24,2D,2C,35,3C) map to lowercase ASCII.
  - Keys a s d f g h j (1C,1B,23,2B,34,33,3B) map to lowercase ASCII.
- Sub-module ps2_rx_frame handles sync, edge detect, bit shift, frame check and watchdog. It outputs rx_byte with a one-cycle rx_strobe, plus rx_err.
- The top level holds the byte FSM and the output registers.

Test Plan:
- Reset then idle pins high for 10000 cycles -> ps2_asci=0x00, no key_valid or frame_err pulses.
- Frame 0x1C (parity 0), 80 us ps2_clk period -> ps2_asci=0x61 4 cycles after the 11th falling edge, one key_valid pulse. Then frames F0,1C -> ps2_asci=0x00 with one key_valid pulse.
- Make 0x1C, make 0x1B, break 0x1C -> ps2_asci goes 0x61 then 0x73 and stays 0x73. Then break 0x1B -> 0x00. Three key_valid pulses in total.
- Frame 0x23 with parity bit flipped -> frame_err pulse, ps2_asci unchanged. The next good 0x23 -> 0x64.
- Stop clocking after 5 bits -> frame_err pulses at TIMEOUT_CYC cycles after the 5th edge. A following full 0x2B frame -> 0x66.
- Sequence E0,75 then E0,F0,75 then F0,1C with nothing held -> no key_valid. Assert rst mid-frame -> outputs 0, and the next good 0x16 frame -> 0x31.
